// File: rtl/vq_decompress_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vq_decompress_top                                             |
// | Purpose  : Vector-quantization image decompressor. For every pixel n it  |
// |            reads tag RAM2[n] and looks up codeword RAM1[tag[5:0]]. It    |
// |            then writes that codeword to RAM3[n] in ascending order, and  |
// |            raises a sticky done flag when all pixels are written.        |
// | Ports    : clk            - system clock, rising edge                    |
// |            rst            - asynchronous, active-low reset               |
// |            RAM1_Q/A/D/WE/OE - codebook RAM (read only, D/WE tied 0)      |
// |            RAM2_Q/A/D/WE/OE - tag stream RAM (read only, D/WE tied 0)    |
// |            RAM3_A/D/WE/OE   - output pixel RAM (write only, OE tied 0)   |
// |            done           - completion flag, held until reset            |
// | Options  : CODEBOOK_CACHE_EN - preload the codebook into a register file |
// |            in a LOAD state, then run a 2-stage pipeline with no RAM1     |
// |            traffic. Undefined: 3-stage pipeline reading RAM1 per pixel.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vq_decompress_top #(
   parameter int NUM_PIXELS = 4096,
   parameter int CB_SIZE    = 64,
   parameter int ADDR_W     = 20,
   parameter int DATA_W     = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] RAM1_Q,
   output logic [ADDR_W-1:0] RAM1_A,
   output logic [DATA_W-1:0] RAM1_D,
   output logic              RAM1_WE,
   output logic              RAM1_OE,
   input  logic [DATA_W-1:0] RAM2_Q,
   output logic [ADDR_W-1:0] RAM2_A,
   output logic [DATA_W-1:0] RAM2_D,
   output logic              RAM2_WE,
   output logic              RAM2_OE,
   output logic [ADDR_W-1:0] RAM3_A,
   output logic [DATA_W-1:0] RAM3_D,
   output logic              RAM3_WE,
   output logic              RAM3_OE,
   output logic              done
);

   localparam int                c_IDX_W    = $clog2(CB_SIZE);
   localparam logic [ADDR_W-1:0] c_LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

   localparam logic [2:0] c_ST_IDLE  = 3'd0;
   localparam logic [2:0] c_ST_RUN   = 3'd2;
   localparam logic [2:0] c_ST_DRAIN = 3'd3;
   localparam logic [2:0] c_ST_DONE  = 3'd4;
`ifdef CODEBOOK_CACHE_EN
   localparam logic [2:0] c_ST_LOAD  = 3'd1;
   localparam int                 c_CNT_W   = $clog2(CB_SIZE + 1);
   localparam logic [c_CNT_W-1:0] c_LD_LAST = c_CNT_W'(CB_SIZE);
`endif

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic               w_issue_nxt;
   logic [ADDR_W-1:0]  w_pix_nxt;
   logic               w_done_nxt;
   logic               w_pipe_busy;

   // S0 issue registers: RAM2_A doubles as the pixel counter n.
   logic               r_ram2_oe;
   logic [ADDR_W-1:0]  r_ram2_a;
   // S1 valid and the delayed pixel address travelling with it.
   logic               r_v1;
   logic [ADDR_W-1:0]  r_n1;
   logic               r_done;

   logic [c_IDX_W-1:0] w_tag;
   // Tag bits above the codebook index carry no meaning.
   logic               w_unused_tag_hi;

   assign w_tag           = RAM2_Q[c_IDX_W-1:0];
   assign w_unused_tag_hi = &{1'b0, RAM2_Q[DATA_W-1:c_IDX_W]};

`ifdef CODEBOOK_CACHE_EN
   logic [c_CNT_W-1:0] r_ld_cnt;
   logic [c_CNT_W-1:0] w_ld_cnt_nxt;
   logic               w_ld_rd_nxt;
   logic               r_ram1_oe;
   logic [ADDR_W-1:0]  r_ram1_a;
   logic               r_ld_v;
   logic [c_IDX_W-1:0] r_ld_k;
   logic [DATA_W-1:0]  r_cb_mem [CB_SIZE];
`else
   logic               r_v2;
   logic [ADDR_W-1:0]  r_n2;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
`ifdef CODEBOOK_CACHE_EN
         c_ST_IDLE:  w_state_nxt = c_ST_LOAD;
         // One extra LOAD cycle lets the last codebook word land in the file.
         c_ST_LOAD:  if (r_ld_cnt == c_LD_LAST) w_state_nxt = c_ST_RUN;
`else
         c_ST_IDLE:  w_state_nxt = c_ST_RUN;
`endif
         c_ST_RUN:   if (r_ram2_a == c_LAST_PIX) w_state_nxt = c_ST_DRAIN;
         c_ST_DRAIN: if (!w_pipe_busy) w_state_nxt = c_ST_DONE;
         c_ST_DONE:  w_state_nxt = c_ST_DONE;
         default:    w_state_nxt = c_ST_IDLE;
      endcase
   end

   // ---------------- FSM: output logic ----------------
   // Computes next values of the registered outputs from the next state so
   // that the first S0 issue coincides with RUN entry.
   always_comb begin
      w_issue_nxt = (w_state_nxt == c_ST_RUN);
      w_pix_nxt   = '0;
      if (w_issue_nxt && (r_state == c_ST_RUN)) begin
         w_pix_nxt = r_ram2_a + ADDR_W'(1);
      end
      w_done_nxt  = (w_state_nxt == c_ST_DONE);
`ifdef CODEBOOK_CACHE_EN
      w_ld_cnt_nxt = (r_state == c_ST_LOAD) ? r_ld_cnt + c_CNT_W'(1) : '0;
      w_ld_rd_nxt  = (w_state_nxt == c_ST_LOAD) && (w_ld_cnt_nxt != c_LD_LAST);
`endif
   end

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ram2_oe <= 1'b0;
         r_ram2_a  <= '0;
         r_v1      <= 1'b0;
         r_n1      <= '0;
         r_done    <= 1'b0;
`ifdef CODEBOOK_CACHE_EN
         r_ld_cnt  <= '0;
         r_ram1_oe <= 1'b0;
         r_ram1_a  <= '0;
         r_ld_v    <= 1'b0;
         r_ld_k    <= '0;
`else
         r_v2      <= 1'b0;
         r_n2      <= '0;
`endif
      end else begin
         r_ram2_oe <= w_issue_nxt;
         r_ram2_a  <= w_pix_nxt;
         r_v1      <= r_ram2_oe;
         r_n1      <= r_ram2_a;
         r_done    <= w_done_nxt;
`ifdef CODEBOOK_CACHE_EN
         r_ld_cnt  <= w_ld_cnt_nxt;
         r_ram1_oe <= w_ld_rd_nxt;
         r_ram1_a  <= w_ld_rd_nxt ? ADDR_W'(w_ld_cnt_nxt) : '0;
         r_ld_v    <= r_ram1_oe;
         r_ld_k    <= r_ram1_a[c_IDX_W-1:0];
`else
         r_v2      <= r_v1;
         r_n2      <= r_n1;
`endif
      end
   end

`ifdef CODEBOOK_CACHE_EN
   // Codebook file needs no reset: every entry is reloaded before use.
   always_ff @(posedge clk) begin
      if (r_ld_v) begin
         r_cb_mem[r_ld_k] <= RAM1_Q;
      end
   end

   assign w_pipe_busy = r_v1;
   assign RAM1_A      = r_ram1_a;
   assign RAM1_OE     = r_ram1_oe;
   assign RAM3_A      = r_n1;
   assign RAM3_WE     = r_v1;
   assign RAM3_D      = r_v1 ? r_cb_mem[w_tag] : '0;
`else
   // RAM1_A/RAM3_D come straight from the RAM output registers; gating with
   // the stage valid keeps them at zero outside the pipeline.
   assign w_pipe_busy = r_v1 | r_v2;
   assign RAM1_A      = r_v1 ? ADDR_W'(w_tag) : '0;
   assign RAM1_OE     = r_v1;
   assign RAM3_A      = r_n2;
   assign RAM3_WE     = r_v2;
   assign RAM3_D      = r_v2 ? RAM1_Q : '0;
`endif

   assign RAM2_A  = r_ram2_a;
   assign RAM2_OE = r_ram2_oe;
   assign done    = r_done;

   assign RAM1_D  = '0;
   assign RAM1_WE = 1'b0;
   assign RAM2_D  = '0;
   assign RAM2_WE = 1'b0;
   assign RAM3_OE = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vq_decompress_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vq_decompress_top                                          |
// | Purpose  : Self-checking bench for vq_decompress_top. Models the three   |
// |            RAMs and checks every image against RAM3[n] = RAM1[RAM2[n]%64]|
// |            along with latency, write count and ordering.                 |
// | Options  : CODEBOOK_CACHE_EN selects the expected latency / RAM1 reads.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_vq_decompress_top;

   localparam int c_NPIX    = 4096;
   localparam int c_CB      = 64;
   localparam int c_TIMEOUT = 6000;
`ifdef CODEBOOK_CACHE_EN
   localparam int c_EXP_LAT = c_NPIX + c_CB + 4;
   localparam int c_EXP_RD1 = c_CB;
`else
   localparam int c_EXP_LAT = c_NPIX + 4;
   localparam int c_EXP_RD1 = c_NPIX;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] RAM1_Q = '0;
   logic [23:0] RAM2_Q = '0;
   logic [19:0] RAM1_A, RAM2_A, RAM3_A;
   logic [23:0] RAM1_D, RAM2_D, RAM3_D;
   logic        RAM1_WE, RAM1_OE, RAM2_WE, RAM2_OE, RAM3_WE, RAM3_OE, done;

   always #5 clk = ~clk;

   vq_decompress_top u_dut (
      .clk     (clk),
      .rst     (rst),
      .RAM1_Q  (RAM1_Q),
      .RAM1_A  (RAM1_A),
      .RAM1_D  (RAM1_D),
      .RAM1_WE (RAM1_WE),
      .RAM1_OE (RAM1_OE),
      .RAM2_Q  (RAM2_Q),
      .RAM2_A  (RAM2_A),
      .RAM2_D  (RAM2_D),
      .RAM2_WE (RAM2_WE),
      .RAM2_OE (RAM2_OE),
      .RAM3_A  (RAM3_A),
      .RAM3_D  (RAM3_D),
      .RAM3_WE (RAM3_WE),
      .RAM3_OE (RAM3_OE),
      .done    (done)
   );

   logic [23:0] mem1 [c_CB];
   logic [23:0] mem2 [c_NPIX];
   logic [23:0] mem3 [c_NPIX];

   // Per-run activity counters, cleared while reset is held.
   int run_we       = 0;
   int run_rd1      = 0;
   int order_err    = 0;
   int range_err    = 0;
   int we_when_done = 0;

   int checks   = 0;
   int failures = 0;

   // RAM models plus bus monitor.
   always @(posedge clk) begin
      if (RAM1_OE) RAM1_Q <= mem1[RAM1_A[5:0]];
      if (RAM2_OE) RAM2_Q <= mem2[RAM2_A[11:0]];
      if (RAM3_WE) mem3[RAM3_A[11:0]] <= RAM3_D;
      if (!rst) begin
         run_we       = 0;
         run_rd1      = 0;
         order_err    = 0;
         range_err    = 0;
         we_when_done = 0;
      end else begin
         if (RAM1_OE) begin
            run_rd1++;
            if (RAM1_A >= 20'(c_CB)) range_err++;
         end
         if (RAM2_OE && RAM2_A >= 20'(c_NPIX)) range_err++;
         if (RAM3_WE) begin
            if (RAM3_A != 20'(run_we)) order_err++;
            if (RAM3_A >= 20'(c_NPIX)) range_err++;
            if (done) we_when_done++;
            run_we++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < c_NPIX; n++) mem3[n] = 24'($urandom);
      repeat (3) @(negedge clk);
      check({tag, "/rst_done"}, 32'(done), 32'd0);
      check({tag, "/rst_outputs_zero"},
            32'(|{RAM1_A, RAM1_D, RAM1_WE, RAM1_OE, RAM2_A, RAM2_D, RAM2_WE,
                  RAM2_OE, RAM3_A, RAM3_D, RAM3_WE, RAM3_OE}), 32'd0);
   endtask

   task automatic run_and_check(input string tag);
      int cyc;
      int bad;
      int first_bad;
      apply_reset(tag);
      @(negedge clk);
      rst = 1'b1;
      cyc = 0;
      while (cyc < c_TIMEOUT) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done === 1'b1) break;
      end
      check({tag, "/done_latency"}, 32'(cyc), 32'(c_EXP_LAT));
      repeat (8) @(negedge clk);
      check({tag, "/done_sticky"}, 32'(done), 32'd1);
      check({tag, "/ram3_write_count"}, 32'(run_we), 32'(c_NPIX));
      check({tag, "/ram1_read_count"}, 32'(run_rd1), 32'(c_EXP_RD1));
      check({tag, "/write_order_errors"}, 32'(order_err), 32'd0);
      check({tag, "/address_range_errors"}, 32'(range_err), 32'd0);
      check({tag, "/writes_after_done"}, 32'(we_when_done), 32'd0);
      check({tag, "/tied_outputs"},
            32'(|{RAM1_D, RAM1_WE, RAM2_D, RAM2_WE, RAM3_OE}), 32'd0);
      bad = 0;
      first_bad = -1;
      for (int n = 0; n < c_NPIX; n++) begin
         if (mem3[n] !== mem1[mem2[n][5:0]]) begin
            bad++;
            if (first_bad < 0) first_bad = n;
         end
      end
      if (first_bad >= 0)
         $display("note %s: first differing pixel %0d", tag, first_bad);
      check({tag, "/pixel_errors"}, 32'(bad), 32'd0);
   endtask

   initial begin
      int cyc;

      // Image 1: structured codebook, tags n%64.
      for (int k = 0; k < c_CB; k++) begin
         mem1[k] = {8'(k), ~8'(k), 8'(k) ^ 8'h5A};
      end
      for (int n = 0; n < c_NPIX; n++) mem2[n] = 24'(n % c_CB);
      run_and_check("ramp");

      // Image 2: every tag 63, top codeword all ones.
      for (int k = 0; k < c_CB; k++) mem1[k] = 24'($urandom);
      mem1[63] = 24'hFFFFFF;
      for (int n = 0; n < c_NPIX; n++) mem2[n] = 24'd63;
      run_and_check("tag63");

      // Image 3: high tag bits set, only index 5 selects.
      for (int k = 0; k < c_CB; k++) mem1[k] = 24'($urandom);
      for (int n = 0; n < c_NPIX; n++) mem2[n] = 24'hABCDC5;
      run_and_check("hibits");

      // Image 4: random codebook and random full-width tags.
      for (int k = 0; k < c_CB; k++) mem1[k] = 24'($urandom);
      for (int n = 0; n < c_NPIX; n++) mem2[n] = 24'($urandom);
      run_and_check("random");

      // Image 5: abort at pixel 1000, change the tags, rerun.
      for (int k = 0; k < c_CB; k++) mem1[k] = 24'($urandom);
      for (int n = 0; n < c_NPIX; n++) mem2[n] = 24'($urandom);
      apply_reset("abort");
      @(negedge clk);
      rst = 1'b1;
      cyc = 0;
      while (run_we < 1000 && cyc < c_TIMEOUT) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("abort/reached_pixel_1000", 32'(run_we), 32'd1000);
      check("abort/done_before_abort", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort/async_clear_we", 32'(RAM3_WE), 32'd0);
      check("abort/done_in_reset", 32'(done), 32'd0);
      for (int n = 0; n < c_NPIX; n++) mem2[n] = 24'($urandom_range(0, 127));
      run_and_check("rerun");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vq_decompress_top.md
# vq_decompress_top

Vector-quantization image decompressor. Reads a 64-entry RGB codebook from RAM1 and a 4096-entry tag stream from RAM2. For every pixel it writes the 24-bit codeword selected by that pixel's tag to RAM3, then raises `done`. It is the top-level datapath of the decompress side and attaches directly to three external single-port synchronous RAMs.

## Interface
- `NUM_PIXELS`, 4096: pixels to reconstruct (64×64 image).
- `CB_SIZE`, 64: codebook entries; the tag index width is log2(CB_SIZE) = 6.
- `ADDR_W`, 20: RAM address width.
- `DATA_W`, 24: RAM data width; codeword packing is {R[23:16], G[15:8], B[7:0]}.

Ports (clock and reset first):
- `clk` in 1: system clock, all logic on the rising edge.
- `rst` in 1: reset, asynchronous and active-low. All state clears immediately when asserted.
- `RAM1_Q` in 24: codebook read data.
- `RAM1_A` out 20: codebook address.
- `RAM1_D` out 24: tied to 0.
- `RAM1_WE` out 1: tied to 0.
- `RAM1_OE` out 1: codebook read enable.
- `RAM2_Q` in 24: tag read data; the index is bits [5:0] and higher bits are ignored.
- `RAM2_A` out 20: tag address.
- `RAM2_D` out 24: tied to 0.
- `RAM2_WE` out 1: tied to 0.
- `RAM2_OE` out 1: tag read enable.
- `RAM3_A` out 20: output pixel address.
- `RAM3_D` out 24: output pixel data.
- `RAM3_WE` out 1: output write enable.
- `RAM3_OE` out 1: tied to 0.
- `done` out 1: completion flag, sticky.

## Operation
RAM contract (all three RAMs), sampled at each rising CK edge:
- When WE=1, mem[A] <= D.
- When OE=1, Q <= mem[A]. Read latency is exactly 1 cycle.

Required function:
- For every n in 0..NUM_PIXELS-1: RAM3[n] = RAM1[RAM2[n][5:0]].
- Each RAM3 address is written exactly once, in ascending order.

States:
- IDLE: entered on reset. Moves to RUN on the first clock after reset deasserts (or to LOAD when the macro below is defined).
- RUN: 3-stage pipeline with a throughput of 1 pixel per cycle.
  - S0: RAM2_A = n, RAM2_OE = 1.
  - S1: RAM1_A = RAM2_Q[5:0], RAM1_OE = 1.
  - S2: RAM3_A = n, RAM3_D = RAM1_Q, RAM3_WE = 1.
  - The pixel counter n wraps nowhere. When n reaches NUM_PIXELS-1 at S0, the state moves to DRAIN.
- DRAIN: no new issues; the in-flight pixels finish S1/S2.
- DONE: entered the cycle after the last RAM3 write edge. `done` = 1, all enables 0. Held until reset.

Other rules:
- Reset mid-operation aborts the current run. After release the block restarts from pixel 0. Partial RAM3 contents are simply overwritten.
- The pixel address carried into S2 must be the delayed copy of the S0 address, not the live counter.

## Timing
- Reset values: all addresses 0, all D 0, all WE/OE 0, `done` 0, state IDLE.
- Outputs are registered.
- First RAM3 write: 3 cycles after RUN entry.
- Last RAM3 write: RUN entry + NUM_PIXELS + 2 cycles.
- `done` rises 1 cycle after the last write, i.e. about NUM_PIXELS + 4 cycles after reset release.
- `RAM3_WE` is never asserted in IDLE or DONE.
- There is no back-pressure; the RAMs are always ready.

## Configuration
- `CODEBOOK_CACHE_EN` defined: a LOAD state precedes RUN.
  - LOAD reads RAM1[0..CB_SIZE-1] into an internal 64×24 register file over CB_SIZE+1 cycles.
  - RUN then uses a 2-stage pipeline: S0 reads RAM2; S1 looks up the register file and writes RAM3.
  - RAM1_OE stays 0 after LOAD.
  - `done` latency grows by CB_SIZE+1 and shrinks by 1.
- `CODEBOOK_CACHE_EN` undefined: no register file; RAM1 is read once per pixel as described in Operation.
- The RAM3 contents are identical in both builds.

## Test plan
- Codebook RAM1[k] = {k, ~k, k^8'h5A}, tags RAM2[n] = n%64: every RAM3[n] equals RAM1[n%64]; `done` = 1 and zero mismatches.
- All tags = 63 with RAM1[63] = 24'hFFFFFF: all 4096 RAM3 words = FFFFFF; RAM1_A never exceeds 63.
- Tags with high bits set (RAM2[n] = 24'hABCDC5): only index 5 is used, RAM3[n] = RAM1[5].
- Count cycles from reset release to `done` rising; it must equal the Timing figure for the active build. Check RAM3_WE is high exactly 4096 cycles.
- Reset asserted at pixel 1000 with RAM2 then altered: after the rerun, RAM3 matches the new tags everywhere. `done` stays 0 during reset and until the rerun completes.
- Run both with and without `CODEBOOK_CACHE_EN` on the same images: RAM3 dumps are bit-identical.
